// File: rtl/score_display.sv
// Binary score to six-digit seven-segment display. A serial double-dabble
// converter captures changed scores and updates all digits atomically on completion.

module score_display_seg #(
    parameter bit ACTIVE_LOW = 1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    logic [6:0] lo;

    always_comb begin
        lo = 7'h7F;
        if (!blank) begin
            case (digit)
                4'd0:    lo = 7'h40;
                4'd1:    lo = 7'h79;
                4'd2:    lo = 7'h24;
                4'd3:    lo = 7'h30;
                4'd4:    lo = 7'h19;
                4'd5:    lo = 7'h12;
                4'd6:    lo = 7'h02;
                4'd7:    lo = 7'h78;
                4'd8:    lo = 7'h00;
                4'd9:    lo = 7'h10;
                default: lo = 7'h7F;
            endcase
        end
        seg = ACTIVE_LOW ? lo : ~lo;
    end
endmodule

module score_display #(
    parameter bit ACTIVE_LOW = 1,
    parameter bit BLANK_LZ   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] score,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        busy,
    output logic        overflow,
    output logic        done
);
    localparam int          DIGITS    = 6;
    localparam int          SEG_W     = 7;
    localparam logic [23:0] MAX_VAL   = 24'd999999;
    localparam logic [6:0]  PAT_ZERO  = ACTIVE_LOW ? 7'h40 : 7'h3F;
    localparam logic [6:0]  PAT_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0]  PAT_LEAD  = BLANK_LZ ? PAT_BLANK : PAT_ZERO;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                         state;
    logic [23:0]                    snapshot;
    logic [47:0]                    dd_q;      // {bcd[23:0], binary[23:0]}
    logic [4:0]                     shift_cnt;
    logic                           ovf_pend;
    logic [DIGITS-1:0][SEG_W-1:0]   hex_q;
    logic [DIGITS-1:0][SEG_W-1:0]   seg_next;
    logic [DIGITS-1:0][3:0]         bcd;
    logic [DIGITS-1:0]              blank;

    assign bcd = dd_q[47:24];

    function automatic logic [47:0] dd_step(input logic [47:0] r);
        logic [47:0] t;
        t = r;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[24+4*d +: 4] >= 4'd5)
                t[24+4*d +: 4] = t[24+4*d +: 4] + 4'd3;
        end
        return {t[46:0], 1'b0};
    endfunction

    // Digit 0 always shows; higher digits blank while everything above is zero.
    always_comb begin
        logic run;
        run   = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run      = run && (bcd[i] == 4'd0);
            blank[i] = BLANK_LZ && (i != 0) && run;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        score_display_seg #(.ACTIVE_LOW(ACTIVE_LOW)) u_seg (
            .digit (bcd[g]),
            .blank (blank[g]),
            .seg   (seg_next[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snapshot  <= '0;
            dd_q      <= '0;
            shift_cnt <= '0;
            ovf_pend  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            for (int i = 0; i < DIGITS; i++)
                hex_q[i] <= (i == 0) ? PAT_ZERO : PAT_LEAD;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (score != snapshot) begin
                        snapshot  <= score;
                        dd_q      <= {24'd0, (score > MAX_VAL) ? MAX_VAL : score};
                        ovf_pend  <= (score > MAX_VAL);
                        shift_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    dd_q      <= dd_step(dd_q);
                    shift_cnt <= shift_cnt + 5'd1;
                    if (shift_cnt == 5'd23)
                        state <= DONE;
                end
                DONE: begin
                    hex_q    <= seg_next;
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
endmodule

// File: tb/tb_score_display.sv
// Randomized scoreboard bench for score_display: a decimal-arithmetic reference
// model predicts each displayed result; a monitor checks it on every done pulse.

module tb_score_display;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] score, score2;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0]  b_hex0, b_hex1, b_hex2, b_hex3, b_hex4, b_hex5;
    logic        busy, overflow, done, b_busy, b_overflow, b_done;

    always #5 clk = ~clk;

    score_display dut (
        .clk(clk), .rst(rst), .score(score),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .busy(busy), .overflow(overflow), .done(done)
    );

    score_display #(.ACTIVE_LOW(0), .BLANK_LZ(0)) dut2 (
        .clk(clk), .rst(rst), .score(score2),
        .hex0(b_hex0), .hex1(b_hex1), .hex2(b_hex2), .hex3(b_hex3), .hex4(b_hex4), .hex5(b_hex5),
        .busy(b_busy), .overflow(b_overflow), .done(b_done)
    );

    typedef struct {
        logic [41:0] hex;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          passed = 0;
    int          m_cnt = 0;
    logic [23:0] m_snap = '0;
    bit          exp_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [6:0] pat(input int d, input bit blank, input bit al);
        logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        logic [6:0] t;
        t = blank ? 7'h7F : lut[d];
        return al ? t : ~t;
    endfunction

    // Decimal digits by division; digit i>0 blanks when the value has fewer than i+1 digits.
    function automatic logic [41:0] model_hex(input int v, input bit al, input bit blz);
        logic [41:0] r;
        int          sat, p;
        sat = (v > 999999) ? 999999 : v;
        p   = 1;
        r   = '0;
        for (int i = 0; i < 6; i++) begin
            r[i*7 +: 7] = pat((sat / p) % 10, blz && (i > 0) && (sat < p), al);
            p = p * 10;
        end
        return r;
    endfunction

    // Protocol model: a capture occupies 25 further edges; changes meanwhile are unseen.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt    = 0;
            m_snap   = '0;
            exp_done = 1'b0;
            q.delete();
        end else begin
            exp_done = (m_cnt == 1);
            if (m_cnt != 0) m_cnt--;
            else if (score != m_snap) begin
                exp_t e;
                m_snap = score;
                e.hex  = model_hex(int'(score), 1'b1, 1'b1);
                e.ovf  = (score > 24'd999999);
                q.push_back(e);
                m_cnt  = 25;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_cnt != 0));
        check("done", 64'(done), 64'(exp_done));
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL done_unexpected: got done=1 expected no pending result");
            end else begin
                exp_t e;
                e = q.pop_front();
                check("hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(e.hex));
                check("overflow", 64'(overflow), 64'(e.ovf));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(m_cnt == 0 && score == m_snap) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_hex0", 64'(hex0), 64'h40);
        check("rst_hex1_5", 64'({hex5, hex4, hex3, hex2, hex1}), 64'({5{7'h7F}}));
        check("rst_ovf", 64'(overflow), 64'h0);
    endtask

    initial begin
        rst    = 1'b1;
        score  = '0;
        score2 = '0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        check("rst2_hex", 64'({b_hex5, b_hex4, b_hex3, b_hex2, b_hex1, b_hex0}), 64'({6{7'h3F}}));
        rst    = 1'b0;
        score2 = 24'd80;
        repeat (50) @(negedge clk);
        check_reset_vals();
        check("inv_80", 64'({b_hex5, b_hex4, b_hex3, b_hex2, b_hex1, b_hex0}),
              64'({7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F, 7'h3F}));

        score = 24'd123456;
        wait_idle();
        check("v123456", 64'({hex5, hex4, hex3, hex2, hex1, hex0}),
              64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));

        score = 24'd7;
        wait_idle();
        check("v7", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({{5{7'h7F}}, 7'h78}));
        score = 24'd1000000;
        wait_idle();
        check("sat", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'({6{7'h10}}));
        check("sat_ovf", 64'(overflow), 64'h1);
        score = 24'd5;
        wait_idle();
        check("v5", 64'(hex0), 64'h12);
        check("v5_ovf", 64'(overflow), 64'h0);

        score = 24'd0;
        wait_idle();
        score = 24'd5;
        repeat (10) @(negedge clk);
        score = 24'd42;
        wait_done();
        check("b2b_first", 64'(hex0), 64'h12);
        wait_idle();
        check("b2b_second", 64'({hex1, hex0}), 64'({7'h19, 7'h24}));

        score = 24'd999;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        wait_idle();
        check("v999", 64'({hex3, hex2, hex1, hex0}), 64'({7'h7F, 7'h10, 7'h10, 7'h10}));

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: score = 24'($urandom_range(0, 99));
                1: score = 24'($urandom_range(0, 999999));
                2: score = 24'($urandom_range(1000000, 24'hFFFFFF));
                default: begin
                    case ($urandom_range(0, 3))
                        0: score = 24'd999999;
                        1: score = 24'd1000000;
                        2: score = 24'd0;
                        default: score = 24'd100000;
                    endcase
                end
            endcase
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        wait_idle();
        check("drain", 64'(q.size()), 64'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
